// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution control FSM.
// Holds the state enum, memory-select codes and the state-to-control decode.
package conv_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        LD_FILT,
        LD_IMG,
        WIN,
        MAC,
        STORE,
        WR,
        SHIFT,
        DONE
    } conv_state_t;

    localparam logic [1:0] MEM_SEL_IMG  = 2'd0;
    localparam logic [1:0] MEM_SEL_FILT = 2'd1;
    localparam logic [1:0] MEM_SEL_RES  = 2'd2;

    localparam int PACK_WORDS = 4;
    localparam int MAC_TAPS   = 16;

    typedef struct packed {
        logic       load_x;
        logic       sel_x;
        logic       load_y;
        logic       sel_y;
        logic       load_z;
        logic       sel_z;
        logic [1:0] mem_addr_sel;
        logic       mem_write_en;
        logic       write_buff_en;
        logic       write_buff_counter_en;
        logic       read_buff_counter_en;
        logic       shift_buff;
        logic       write_filter_buff_en;
        logic       write_filter_buff_counter_en;
        logic       read_filter_buff_counter_en;
        logic       write_window_buff_en;
        logic       clear_mac;
        logic       partial_res_en;
        logic       shift_reg_en;
        logic       finalize_shift_reg;
        logic       done;
    } conv_ctrl_t;

    // Moore decode: every control bit is a function of the state alone.
    function automatic conv_ctrl_t decode(input conv_state_t s);
        conv_ctrl_t c;
        c = '0;
        case (s)
            INIT: begin
                c.load_x = 1'b1;
                c.load_y = 1'b1;
                c.load_z = 1'b1;
            end
            LD_FILT: begin
                c.mem_addr_sel                 = MEM_SEL_FILT;
                c.write_filter_buff_en         = 1'b1;
                c.write_filter_buff_counter_en = 1'b1;
                c.load_y                       = 1'b1;
                c.sel_y                        = 1'b1;
            end
            LD_IMG: begin
                c.mem_addr_sel          = MEM_SEL_IMG;
                c.write_buff_en         = 1'b1;
                c.write_buff_counter_en = 1'b1;
                c.load_x                = 1'b1;
                c.sel_x                 = 1'b1;
            end
            WIN: begin
                c.write_window_buff_en = 1'b1;
                c.clear_mac            = 1'b1;
            end
            MAC: begin
                c.partial_res_en              = 1'b1;
                c.read_filter_buff_counter_en = 1'b1;
            end
            STORE: begin
                c.shift_reg_en         = 1'b1;
                c.read_buff_counter_en = 1'b1;
            end
            WR: begin
                c.finalize_shift_reg = 1'b1;
                c.mem_write_en       = 1'b1;
                c.mem_addr_sel       = MEM_SEL_RES;
                c.load_z             = 1'b1;
                c.sel_z              = 1'b1;
            end
            SHIFT: c.shift_buff = 1'b1;
            DONE:  c.done       = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/conv_out_tracker.sv
// Output bookkeeping: job output count, position within the packed word,
// and the image-buffer read-wrap flag carried from STORE to WR.
module conv_out_tracker
    import conv_pkg::*;
#(
    parameter int NUM_OUTPUTS = 48,
    parameter int OUT_CNT_W   = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic store_i,
    input  logic shift_i,
    input  logic rd_cout_i,
    output logic last_in_word_o,
    output logic job_last_o,
    output logic rd_wrap_o
);

    localparam logic [OUT_CNT_W-1:0] LAST_OUT = OUT_CNT_W'(NUM_OUTPUTS);
    localparam logic [1:0]           LAST_PK  = 2'(PACK_WORDS - 1);

    logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [1:0]           pack_cnt_q, pack_cnt_d;
    logic                 rd_wrap_q, rd_wrap_d;

    always_comb begin
        out_cnt_d  = out_cnt_q;
        pack_cnt_d = pack_cnt_q;
        rd_wrap_d  = rd_wrap_q;
        if (clr_i) begin
            out_cnt_d  = '0;
            pack_cnt_d = '0;
        end else if (store_i) begin
            pack_cnt_d = pack_cnt_q + 2'd1;
            if (out_cnt_q != LAST_OUT) begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end
        if (store_i && rd_cout_i) begin
            rd_wrap_d = 1'b1;
        end else if (shift_i) begin
            rd_wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_q  <= '0;
            pack_cnt_q <= '0;
            rd_wrap_q  <= 1'b0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            pack_cnt_q <= pack_cnt_d;
            rd_wrap_q  <= rd_wrap_d;
        end
    end

    assign last_in_word_o = (pack_cnt_q == LAST_PK);
    assign job_last_o     = (out_cnt_q == LAST_OUT);
    assign rd_wrap_o      = rd_wrap_q;

endmodule

// File: rtl/conv_controller.sv
// Convolution job sequencer driving the datapath from its counter carry-outs.
// Define CONV_CTRL_PERF_EN to add the cycle_count performance counter.
module conv_controller
    import conv_pkg::*;
#(
    parameter int NUM_OUTPUTS = 48,
    parameter int OUT_CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cout_filter_write_index,
    input  logic        cout_mac_index,
    input  logic        cout_buff_write_index,
    input  logic        cout_buff_read_index,
    output logic        load_x,
    output logic        sel_x,
    output logic        load_y,
    output logic        sel_y,
    output logic        load_z,
    output logic        sel_z,
    output logic [1:0]  mem_addr_sel,
    output logic        mem_write_en,
    output logic        write_buff_en,
    output logic        write_buff_counter_en,
    output logic        read_buff_counter_en,
    output logic        shift_buff,
    output logic        write_filter_buff_en,
    output logic        write_filter_buff_counter_en,
    output logic        read_filter_buff_counter_en,
    output logic        write_window_buff_en,
    output logic        clear_mac,
    output logic        partial_res_en,
    output logic        shift_reg_en,
    output logic        finalize_shift_reg,
`ifdef CONV_CTRL_PERF_EN
    output logic [15:0] cycle_count,
`endif
    output logic        done
);

    conv_state_t state_q, state_d;
    conv_ctrl_t  ctrl_q;
    logic        last_in_word, job_last, rd_wrap;

    conv_out_tracker #(
        .NUM_OUTPUTS (NUM_OUTPUTS),
        .OUT_CNT_W   (OUT_CNT_W)
    ) u_tracker (
        .clk            (clk),
        .rst            (rst),
        .clr_i          (state_q == INIT),
        .store_i        (state_q == STORE),
        .shift_i        (state_q == SHIFT),
        .rd_cout_i      (cout_buff_read_index),
        .last_in_word_o (last_in_word),
        .job_last_o     (job_last),
        .rd_wrap_o      (rd_wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = INIT;
            INIT:    state_d = LD_FILT;
            LD_FILT: if (cout_filter_write_index) state_d = LD_IMG;
            LD_IMG:  if (cout_buff_write_index) state_d = WIN;
            WIN:     state_d = MAC;
            MAC:     if (cout_mac_index) state_d = STORE;
            STORE: begin
                if (last_in_word)              state_d = WR;
                else if (cout_buff_read_index) state_d = SHIFT;
                else                           state_d = WIN;
            end
            // A read wrap seen in STORE is deferred until the word is written.
            WR: begin
                if (job_last)     state_d = DONE;
                else if (rd_wrap) state_d = SHIFT;
                else              state_d = WIN;
            end
            SHIFT:   state_d = LD_IMG;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they stay pure Moore.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
        end
    end

`ifdef CONV_CTRL_PERF_EN
    logic [15:0] cycle_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
        end else if (state_q == INIT) begin
            cycle_q <= '0;
        end else if (state_q != IDLE && state_q != DONE
                     && cycle_q != 16'hFFFF) begin
            cycle_q <= cycle_q + 16'd1;
        end
    end

    assign cycle_count = cycle_q;
`endif

    assign load_x                       = ctrl_q.load_x;
    assign sel_x                        = ctrl_q.sel_x;
    assign load_y                       = ctrl_q.load_y;
    assign sel_y                        = ctrl_q.sel_y;
    assign load_z                       = ctrl_q.load_z;
    assign sel_z                        = ctrl_q.sel_z;
    assign mem_addr_sel                 = ctrl_q.mem_addr_sel;
    assign mem_write_en                 = ctrl_q.mem_write_en;
    assign write_buff_en                = ctrl_q.write_buff_en;
    assign write_buff_counter_en        = ctrl_q.write_buff_counter_en;
    assign read_buff_counter_en         = ctrl_q.read_buff_counter_en;
    assign shift_buff                   = ctrl_q.shift_buff;
    assign write_filter_buff_en         = ctrl_q.write_filter_buff_en;
    assign write_filter_buff_counter_en = ctrl_q.write_filter_buff_counter_en;
    assign read_filter_buff_counter_en  = ctrl_q.read_filter_buff_counter_en;
    assign write_window_buff_en         = ctrl_q.write_window_buff_en;
    assign clear_mac                    = ctrl_q.clear_mac;
    assign partial_res_en               = ctrl_q.partial_res_en;
    assign shift_reg_en                 = ctrl_q.shift_reg_en;
    assign finalize_shift_reg           = ctrl_q.finalize_shift_reg;
    assign done                         = ctrl_q.done;

endmodule

// File: doc/conv_controller.md
# conv_controller

Control FSM for the convolution datapath. It sequences the whole job: pointer initialisation, filter load, image-buffer fill, window capture, 16-tap MAC, result packing, and memory write-back. It sits directly upstream of the datapath, drives every control input of it, and consumes its four counter carry-outs. It packs results four per memory word and stops after a programmed number of outputs.

## Interface
- NUM_OUTPUTS, default 48: total convolution results per job; must be a multiple of 4.
- OUT_CNT_W, default 6: width of the internal output counter; must satisfy 2^OUT_CNT_W ≥ NUM_OUTPUTS.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- cout_filter_write_index, cout_mac_index, cout_buff_write_index, cout_buff_read_index  in  1 each  datapath counter carry-outs.
- load_x, sel_x, load_y, sel_y, load_z, sel_z  out  1 each  pointer enable and select; sel=0 loads the initial address, sel=1 increments.
- mem_addr_sel  out  2  memory address source: 0 = x (image), 1 = y (filter), 2 = z (result).
- mem_write_en, write_buff_en, write_buff_counter_en, read_buff_counter_en, shift_buff  out  1 each  memory and image-buffer controls.
- write_filter_buff_en, write_filter_buff_counter_en, read_filter_buff_counter_en  out  1 each  filter-buffer controls.
- write_window_buff_en, clear_mac, partial_res_en, shift_reg_en, finalize_shift_reg  out  1 each  window, MAC and packing controls.
- done  out  1  job-complete indication.

## Operation
- Moore FSM. Every output is decoded from the current state only. Any output not listed for a state is 0.
- IDLE: all outputs 0. If start=1, go to INIT.
- INIT: load_x, load_y, load_z = 1 with all sel=0. Clear out_cnt and pack_cnt. Go to LD_FILT.
- LD_FILT: mem_addr_sel=1, write_filter_buff_en, write_filter_buff_counter_en, load_y=1, sel_y=1. Stay until cout_filter_write_index=1, then go to LD_IMG.
- LD_IMG: mem_addr_sel=0, write_buff_en, write_buff_counter_en, load_x=1, sel_x=1. Stay until cout_buff_write_index=1, then go to WIN.
- WIN: write_window_buff_en, clear_mac. Go to MAC.
- MAC: partial_res_en, read_filter_buff_counter_en. Stay until cout_mac_index=1, then go to STORE.
- STORE: shift_reg_en, read_buff_counter_en. Increment pack_cnt (2 bit, wraps) and out_cnt.
  - If pack_cnt=3, go to WR.
  - Otherwise, if cout_buff_read_index=1, go to SHIFT.
  - Otherwise, go to WIN.
- WR: finalize_shift_reg, mem_write_en, mem_addr_sel=2, load_z=1, sel_z=1.
  - If out_cnt=NUM_OUTPUTS, go to DONE.
  - Otherwise, if cout_buff_read_index was captured high in STORE, go to SHIFT.
  - Otherwise, go to WIN.
- SHIFT: shift_buff. Go to LD_IMG to refill four columns.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Flag rd_wrap: a register set in STORE when cout_buff_read_index=1 and cleared in SHIFT. WR uses it to decide whether to visit SHIFT.
- out_cnt saturates at NUM_OUTPUTS. It never wraps within a job.

## Timing
- Reset (asynchronous): state=IDLE, out_cnt=0, pack_cnt=0, rd_wrap=0. Every output is 0 immediately, without waiting for a clock edge.
- Reset asserted mid-job aborts the job. No partial memory write completes after reset is asserted.
- start=1 at edge n in IDLE gives INIT during cycle n+1 and LD_FILT during cycle n+2.
- start is ignored in every state other than IDLE. Holding start high through DONE re-launches the job one cycle after IDLE is entered.
- A cout input is acted on at the edge where it is sampled high. The enable outputs drop in the following cycle. The datapath counter has then wrapped to 0 on that same edge.
- Per output: 1 WIN cycle + 16 MAC cycles + 1 STORE cycle. Add 1 WR cycle every 4th output.
- cout_buff_read_index and pack_cnt=3 can occur in the same STORE cycle. In that case WR runs first, then SHIFT.

## Configuration
- CONV_CTRL_PERF_EN defined: add output cycle_count (16 bit).
  - Cleared in INIT.
  - Increments every cycle while state ≠ IDLE/DONE.
  - Saturates at 16'hFFFF.
  - Holds its value through DONE and IDLE until the next INIT.
  - Reset value 0.
- CONV_CTRL_PERF_EN undefined: the port and the counter are absent.

## Structure
- Shared package conv_pkg holds:
  - enum conv_state_t: IDLE, INIT, LD_FILT, LD_IMG, WIN, MAC, STORE, WR, SHIFT, DONE.
  - constants MEM_SEL_IMG=0, MEM_SEL_FILT=1, MEM_SEL_RES=2.
  - constants PACK_WORDS=4 and MAC_TAPS=16.
- Sub-module conv_out_tracker holds out_cnt, pack_cnt and rd_wrap. It exposes last_in_word and job_last to the FSM.

## Test plan
- Reset, then pulse start → INIT visible 1 cycle after start is sampled; load_x=load_y=load_z=1 with sel=0 for exactly 1 cycle.
- Hold cout_filter_write_index low for 3 cycles, then high → LD_FILT lasts 4 cycles; write_filter_buff_en is high for 4 cycles and mem_addr_sel=1 throughout.
- Model the datapath counters and let 4 outputs complete → shift_reg_en pulses 4 times, followed by exactly one cycle of mem_write_en=1, mem_addr_sel=2 and finalize_shift_reg=1.
- Drive cout_buff_read_index high in the same STORE cycle where pack_cnt=3 → state order STORE, WR, SHIFT, LD_IMG, with shift_buff high for 1 cycle.
- Full job with NUM_OUTPUTS=8 → exactly 2 memory writes, done high for exactly 1 cycle, then IDLE; start pulsed during MAC has no effect.
- Assert rst during MAC at a mid-clock instant → all outputs 0 before the next edge; after release, state is IDLE and a fresh start runs a complete job correctly.
